sram_write_drain: RTL and testbench

Consumer end of the SRAM write-request FIFO: pops 17-bit entries from the synchronous FIFO and turns them into timed asynchronous-SRAM write cycles. Each entry is either an address load or a data word written at the current address with post-increment. The block sits between the write-request FIFO (its writer is the pixel/bus side) and the external SRAM pins. Read traffic and pin tristating are handled elsewhere.

---
 rtl/sram_pkg.sv | 28 ++
 rtl/sram_phase_timer.sv | 35 +++
 rtl/sram_write_drain.sv | 162 ++++++++++++++++
 tb/tb_sram_write_drain.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and timing defaults for the SRAM write drain and read sequencer
// Contents:
//   drain_state_t           write-drain FSM states
//   ENTRY_ADDR_BIT          bit index of the is_addr flag in a default-width FIFO entry
//   DEFAULT_*               default SRAM widths and cycle timings
//   PHASE_TIMER_WIDTH       width of the phase down-counter
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        SETUP = 3'd3,
        PULSE = 3'd4,
        HOLD  = 3'd5
    } drain_state_t;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_ADDR_WIDTH   = 16;
    localparam int ENTRY_ADDR_BIT       = DEFAULT_DATA_WIDTH;

    localparam int DEFAULT_SETUP_CYCLES = 1;
    localparam int DEFAULT_PULSE_CYCLES = 2;
    localparam int DEFAULT_HOLD_CYCLES  = 1;

    localparam int PHASE_TIMER_WIDTH    = 16;

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter timing one SRAM cycle phase
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       restart the phase; asserted on the cycle before the phase begins
//   cycles     length of the phase in clock cycles (>= 1)
//   done       high on the last cycle of the phase
module sram_phase_timer
    import sram_pkg::*;
#(
    parameter int WIDTH = PHASE_TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] cycles,
    output logic             done
);

    logic [WIDTH-1:0] remaining;

    // Loading cycles-1 makes the first cycle of the phase count as one, so a
    // phase of N cycles reaches zero (done) on its Nth cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= cycles - 1'b1;
        end else if (remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign done = (remaining == '0);

endmodule

// File: rtl/sram_write_drain.sv
// rtl/sram_write_drain.sv - drains the write-request FIFO into timed asynchronous SRAM write cycles
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   enable          permits new pops; a started entry always completes
//   fifo_empty      FIFO empty flag, sampled only in IDLE
//   fifo_rd_en      single-cycle pop request
//   fifo_data       registered FIFO output: {is_addr, payload}
//   sram_addr       SRAM address (post-incremented after each data write)
//   sram_dq_out     SRAM write data
//   sram_dq_oe      drive the SRAM data bus
//   sram_ce_n       chip enable, active low
//   sram_we_n       write enable, active low
//   busy            high whenever the FSM is not in IDLE
//   words_written   count of completed data writes, wraps
module sram_write_drain
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int SETUP_CYCLES = DEFAULT_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH:0]   fifo_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  busy,
    output logic [15:0]           words_written
);

    localparam logic [PHASE_TIMER_WIDTH-1:0] SETUP_LOAD = PHASE_TIMER_WIDTH'(SETUP_CYCLES);
    localparam logic [PHASE_TIMER_WIDTH-1:0] PULSE_LOAD = PHASE_TIMER_WIDTH'(PULSE_CYCLES);
    localparam logic [PHASE_TIMER_WIDTH-1:0] HOLD_LOAD  = PHASE_TIMER_WIDTH'(HOLD_CYCLES);

    drain_state_t                 state, nextState;
    logic                         loadTimer;
    logic [PHASE_TIMER_WIDTH-1:0] loadCycles;
    logic                         phaseDone;
    logic                         entryIsAddr;
    logic [ADDR_WIDTH-1:0]        addrReg;
    logic [DATA_WIDTH-1:0]        dataReg;
    logic [15:0]                  wordCount;

    // The is_addr flag sits just above the payload.
    assign entryIsAddr = fifo_data[DATA_WIDTH];

    sram_phase_timer #(
        .WIDTH (PHASE_TIMER_WIDTH)
    ) phaseTimer (
        .clk    (clk),
        .rst    (rst),
        .load   (loadTimer),
        .cycles (loadCycles),
        .done   (phaseDone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset releases we_n and ce_n in the same instant.
    always_comb begin
        nextState  = state;
        loadTimer  = 1'b0;
        loadCycles = '0;
        fifo_rd_en = 1'b0;
        sram_ce_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable && !fifo_empty) begin
                    nextState = POP;
                end
            end
            POP: begin
                fifo_rd_en = 1'b1;
                nextState  = LATCH;
            end
            LATCH: begin
                if (entryIsAddr) begin
                    nextState = IDLE;
                end else begin
                    nextState  = SETUP;
                    loadTimer  = 1'b1;
                    loadCycles = SETUP_LOAD;
                end
            end
            SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                if (phaseDone) begin
                    nextState  = PULSE;
                    loadTimer  = 1'b1;
                    loadCycles = PULSE_LOAD;
                end
            end
            PULSE: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_we_n  = 1'b0;
                if (phaseDone) begin
                    nextState  = HOLD;
                    loadTimer  = 1'b1;
                    loadCycles = HOLD_LOAD;
                end
            end
            HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                if (phaseDone) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Address and data only move in LATCH or on the final HOLD cycle, which
    // keeps the pins stable across the whole SETUP..HOLD window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrReg   <= '0;
            dataReg   <= '0;
            wordCount <= '0;
        end else begin
            if (state == LATCH) begin
                if (entryIsAddr) begin
                    addrReg <= fifo_data[ADDR_WIDTH-1:0];
                end else begin
                    dataReg <= fifo_data[DATA_WIDTH-1:0];
                end
            end
            if (state == HOLD && phaseDone) begin
                addrReg   <= addrReg + 1'b1;
                wordCount <= wordCount + 1'b1;
            end
        end
    end

    assign sram_addr     = addrReg;
    assign sram_dq_out   = dataReg;
    assign words_written = wordCount;

endmodule

// File: tb/tb_sram_write_drain.sv
// tb/tb_sram_write_drain.sv - scoreboard bench for sram_write_drain
module tb_sram_write_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        fifoEmpty = 1'b1;
    logic        fifoRdEn;
    logic [16:0] fifoData = '0;
    logic [15:0] sramAddr, sramDqOut, wordsWritten;
    logic        sramDqOe, sramCeN, sramWeN, busy;

    logic        enable2 = 1'b0;
    logic        fifo2Empty = 1'b1;
    logic        fifo2RdEn;
    logic [16:0] fifo2Data = 17'h05A5A;
    logic [15:0] sramAddr2, sramDqOut2, wordsWritten2;
    logic        sramDqOe2, sramCeN2, sramWeN2, busy2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [16:0] fifoQ[$];
    logic [31:0] expQ[$];
    int          popTimes[$];
    int          busyRuns[$];
    logic [15:0] modelAddr = '0;
    logic        popReq = 1'b0;

    sram_write_drain dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifoEmpty),
        .fifo_rd_en    (fifoRdEn),
        .fifo_data     (fifoData),
        .sram_addr     (sramAddr),
        .sram_dq_out   (sramDqOut),
        .sram_dq_oe    (sramDqOe),
        .sram_ce_n     (sramCeN),
        .sram_we_n     (sramWeN),
        .busy          (busy),
        .words_written (wordsWritten)
    );

    sram_write_drain #(
        .SETUP_CYCLES (3),
        .PULSE_CYCLES (1),
        .HOLD_CYCLES  (2)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable2),
        .fifo_empty    (fifo2Empty),
        .fifo_rd_en    (fifo2RdEn),
        .fifo_data     (fifo2Data),
        .sram_addr     (sramAddr2),
        .sram_dq_out   (sramDqOut2),
        .sram_dq_oe    (sramDqOe2),
        .sram_ce_n     (sramCeN2),
        .sram_we_n     (sramWeN2),
        .busy          (busy2),
        .words_written (wordsWritten2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushAddr(input logic [15:0] a);
        fifoQ.push_back({1'b1, a});
        modelAddr = a;
        fifoEmpty = 1'b0;
    endtask

    task automatic pushData(input logic [15:0] d);
        fifoQ.push_back({1'b0, d});
        expQ.push_back({modelAddr, d});
        modelAddr = modelAddr + 16'd1;
        fifoEmpty = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((fifoQ.size() != 0 || busy) && n < 500) begin
            step();
            n++;
        end
        chk(name, n < 500, 1'b1);
    endtask

    task automatic waitWeLow(input string name);
        int n = 0;
        while (sramWeN && n < 200) begin
            step();
            n++;
        end
        chk(name, n < 200, 1'b1);
    endtask

    // Registered FIFO model: the request seen in a cycle is served at its closing edge.
    always @(posedge clk) begin
        if (popReq && !rst) begin
            if (fifoQ.size() > 0) fifoData <= fifoQ.pop_front();
            fifoEmpty = (fifoQ.size() == 0);
        end
    end

    logic        prevCe = 1'b1, prevWe = 1'b1, haveCur = 1'b0;
    logic [31:0] cur = '0;
    int          weLow = 0, busyRun = 0, popCount = 0;

    always @(negedge clk) begin
        popReq = fifoRdEn;
        if (rst) begin
            prevCe = 1'b1; prevWe = 1'b1; haveCur = 1'b0; weLow = 0; busyRun = 0;
        end else begin
            if (fifoRdEn) begin
                popCount++;
                popTimes.push_back(cyc);
                chk("pop_nonempty", fifoQ.size() != 0, 1'b1);
            end
            if (busy) busyRun++;
            else if (busyRun != 0) begin
                busyRuns.push_back(busyRun);
                busyRun = 0;
            end
            if (!sramCeN && prevCe) begin
                if (expQ.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
                else begin
                    cur = expQ.pop_front();
                    haveCur = 1'b1;
                end
            end
            if (!sramCeN && haveCur) begin
                chk("wr_addr", sramAddr, cur[31:16]);
                chk("wr_data", sramDqOut, cur[15:0]);
                chk("wr_oe", sramDqOe, 1'b1);
            end
            if (!sramWeN) weLow++;
            else if (!prevWe) begin
                chk("we_low_width", weLow, 2);
                weLow = 0;
            end
            if (sramCeN) haveCur = 1'b0;
            prevCe = sramCeN;
            prevWe = sramWeN;
        end
    end

    logic prevCe2 = 1'b1, prevWe2 = 1'b1;
    int   ceRun2 = 0, weRun2 = 0, ceWidth2 = -1, weWidth2 = -1;

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo2RdEn) fifo2Empty = 1'b1;
            if (!sramCeN2) ceRun2++;
            else if (!prevCe2) begin ceWidth2 = ceRun2; ceRun2 = 0; end
            if (!sramWeN2) weRun2++;
            else if (!prevWe2) begin weWidth2 = weRun2; weRun2 = 0; end
            prevCe2 = sramCeN2;
            prevWe2 = sramWeN2;
        end
    end

    task automatic chkResetState(input string tag);
        chk({tag, "_we_n"}, sramWeN, 1'b1);
        chk({tag, "_ce_n"}, sramCeN, 1'b1);
        chk({tag, "_oe"}, sramDqOe, 1'b0);
        chk({tag, "_rd_en"}, fifoRdEn, 1'b0);
        chk({tag, "_addr"}, sramAddr, 16'h0000);
        chk({tag, "_dq"}, sramDqOut, 16'h0000);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_words"}, wordsWritten, 16'h0000);
    endtask

    initial begin
        int pc;
        int n;
        #2 rst = 1'b1;
        #1 chkResetState("reset");
        step(); step();
        rst = 1'b0;

        // single write at an explicit address
        enable = 1'b1;
        pushAddr(16'h0100);
        pushData(16'hABCD);
        waitIdle("t1_idle");
        chk("t1_addr", sramAddr, 16'h0101);
        chk("t1_words", wordsWritten, 16'd1);

        // burst: address entry then four data words
        step();
        popTimes.delete();
        busyRuns.delete();
        pushAddr(16'h0010);
        pushData(16'h1111);
        pushData(16'h2222);
        pushData(16'h3333);
        pushData(16'h4444);
        waitIdle("t2_idle");
        step();
        chk("t2_pops", popTimes.size(), 5);
        if (popTimes.size() == 5)
            for (int i = 1; i < 5; i++)
                chk("t2_pop_spacing", popTimes[i] - popTimes[i-1], (i == 1) ? 3 : 7);
        chk("t2_busy_runs", busyRuns.size(), 5);
        if (busyRuns.size() == 5)
            for (int i = 0; i < 5; i++)
                chk("t2_busy_len", busyRuns[i], (i == 0) ? 2 : 6);
        chk("t2_addr", sramAddr, 16'h0014);
        chk("t2_words", wordsWritten, 16'd5);

        // address wrap
        pushAddr(16'hFFFF);
        pushData(16'h1234);
        pushData(16'h5678);
        waitIdle("t3_idle");
        chk("t3_addr", sramAddr, 16'h0001);
        chk("t3_words", wordsWritten, 16'd7);

        // enable low holds off pops; dropping it mid-pulse finishes the write
        enable = 1'b0;
        pushData(16'h9999);
        pushData(16'h7777);
        pc = popCount;
        repeat (10) step();
        chk("t4_no_pop", popCount, pc);
        chk("t4_idle", busy, 1'b0);
        enable = 1'b1;
        waitWeLow("t4_we");
        enable = 1'b0;
        pc = popCount;
        n = 0;
        while (busy && n < 50) begin step(); n++; end
        chk("t4_done", n < 50, 1'b1);
        chk("t4_words", wordsWritten, 16'd8);
        chk("t4_left", fifoQ.size(), 1);
        repeat (10) step();
        chk("t4_no_more_pop", popCount, pc);
        chk("t4_still_idle", busy, 1'b0);
        chk("t4_addr", sramAddr, 16'h0002);

        // reset in the second pulse cycle
        enable = 1'b1;
        waitWeLow("t5_we");
        step();
        chk("t5_in_pulse", sramWeN, 1'b0);
        rst = 1'b1;
        #1 chkResetState("t5_rst");
        modelAddr = 16'h0000;
        step(); step();
        rst = 1'b0;
        pushData(16'h2222);
        pushData(16'h3333);
        waitIdle("t5_idle");
        chk("t5_addr", sramAddr, 16'h0002);
        chk("t5_words", wordsWritten, 16'd2);

        // non-default timing instance
        fifo2Empty = 1'b0;
        enable2 = 1'b1;
        n = 0;
        while (ceWidth2 < 0 && n < 100) begin step(); n++; end
        chk("t6_done", n < 100, 1'b1);
        step(); step();
        chk("t6_ce_width", ceWidth2, 6);
        chk("t6_we_width", weWidth2, 1);
        chk("t6_words", wordsWritten2, 16'd1);
        chk("t6_addr", sramAddr2, 16'h0001);
        chk("t6_idle", busy2, 1'b0);

        chk("scoreboard_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
